// File: rtl/lfm_phase_gen_if.sv
// -----------------------------------------------------------------------------
// lfm_phase_gen_if
//   Bundles the request side and the ROM/output side of the LFM phase
//   generator into one interface.
//
//   Handshake: a burst request is START high for one cycle. The request is
//   taken only while the generator is idle, DS_READY is high and DURATION is
//   non-zero. Any other request is dropped silently, with no pulses and no
//   state change. No back-pressure is applied once a burst is running. A
//   ROM_ADDR value is meaningful only in a cycle where ADDR_VALID is high.
//
//   Signals (master = requester/consumer, slave = generator):
//     START, DS_READY, F_START, F_STEP, DURATION : master -> slave
//     BUSY, ROM_ADDR, ADDR_VALID,
//     SIGN_LFM_START_CALC, SIGN_LFM_STOP_CALC    : slave -> master
// -----------------------------------------------------------------------------
interface lfm_phase_gen_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DUR_W   = 16
);
  logic               START;
  logic               DS_READY;
  logic [PHASE_W-1:0] F_START;
  logic [PHASE_W-1:0] F_STEP;
  logic [DUR_W-1:0]   DURATION;
  logic               BUSY;
  logic [ADDR_W-1:0]  ROM_ADDR;
  logic               ADDR_VALID;
  logic               SIGN_LFM_START_CALC;
  logic               SIGN_LFM_STOP_CALC;

  modport master (
    output START, DS_READY, F_START, F_STEP, DURATION,
    input  BUSY, ROM_ADDR, ADDR_VALID, SIGN_LFM_START_CALC, SIGN_LFM_STOP_CALC
  );

  modport slave (
    input  START, DS_READY, F_START, F_STEP, DURATION,
    output BUSY, ROM_ADDR, ADDR_VALID, SIGN_LFM_START_CALC, SIGN_LFM_STOP_CALC
  );
endinterface

// File: rtl/lfm_phase_gen.sv
// -----------------------------------------------------------------------------
// lfm_phase_gen
//   LFM (chirp) phase generator. An accepted start request begins a burst of
//   DURATION samples. For each sample the generator drives the top ADDR_W bits
//   of a 32-bit phase accumulator as the sine-ROM address. The tuning word
//   that advances the phase grows by F_STEP every sample, which gives a linear
//   frequency ramp. One-cycle START_CALC and STOP_CALC pulses mark the two ends
//   of the burst for the downstream output register.
//
//   Ports:
//     CLK         : clock, rising edge
//     RESET       : synchronous, active-high reset
//     bus         : lfm_phase_gen_if.slave (request inputs, ROM/pulse outputs)
//     dbg_state_o : current FSM state (0 = IDLE, 1 = RUN)
//
//   Configuration macro:
//     LFM_ADDR_ROUND_EN : when defined, the ROM address is rounded to the
//                         nearest entry instead of truncated. Pulse timing
//                         does not change.
// -----------------------------------------------------------------------------
module lfm_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 12,
  parameter int DUR_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  lfm_phase_gen_if.slave     bus,
  output logic               dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W-1:0] freq_q;
  logic [PHASE_W-1:0] step_q;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   cnt_q;
  logic               busy_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               valid_q;
  logic               start_q;
  logic               stop_q;

  logic [PHASE_W-1:0] phase_d;
  logic [PHASE_W-1:0] freq_d;
  logic [DUR_W-1:0]   cnt_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               last_d;
  logic               accept_d;

`ifdef LFM_ADDR_ROUND_EN
  // Half of one ROM step. Adding it before truncation rounds to the nearest
  // entry. The sum wraps modulo 2^PHASE_W, so the top entry rounds up to 0.
  localparam logic [PHASE_W-1:0] HALF_LSB = PHASE_W'(1) << (PHASE_W - ADDR_W - 1);
  logic [PHASE_W-1:0] phase_rnd;
`endif

  always_comb begin
    phase_d  = phase_q + freq_q;   // modulo 2^PHASE_W, wrap is intended
    freq_d   = freq_q + step_q;    // two's complement step allows a down-chirp
    cnt_d    = cnt_q + DUR_W'(1);
    // dur_q is never 0 inside a burst, so dur_q - 1 cannot underflow.
    last_d   = (cnt_q == (dur_q - DUR_W'(1)));
    accept_d = bus.START && bus.DS_READY && (bus.DURATION != '0);
`ifdef LFM_ADDR_ROUND_EN
    phase_rnd = phase_q + HALF_LSB;
    addr_d    = phase_rnd[PHASE_W-1 -: ADDR_W];
`else
    addr_d    = phase_q[PHASE_W-1 -: ADDR_W];
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      phase_q <= '0;
      freq_q  <= '0;
      step_q  <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Each idle edge clears the output bus. The first idle edge after a
          // burst ends that burst's last sample and its STOP pulse.
          busy_q  <= 1'b0;
          addr_q  <= '0;
          valid_q <= 1'b0;
          start_q <= 1'b0;
          stop_q  <= 1'b0;
          if (accept_d) begin
            step_q  <= bus.F_STEP;
            dur_q   <= bus.DURATION;
            phase_q <= '0;
            freq_q  <= bus.F_START;
            cnt_q   <= '0;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Inputs are not sampled here, so a running burst ignores later
          // requests and any change to the request fields.
          start_q <= 1'b0;
          addr_q  <= addr_d;
          valid_q <= 1'b1;
          phase_q <= phase_d;
          freq_q  <= freq_d;
          cnt_q   <= cnt_d;
          stop_q  <= last_d;
          if (last_d) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY                = busy_q;
  assign bus.ROM_ADDR            = addr_q;
  assign bus.ADDR_VALID          = valid_q;
  assign bus.SIGN_LFM_START_CALC = start_q;
  assign bus.SIGN_LFM_STOP_CALC  = stop_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_lfm_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_lfm_phase_gen
//   Directed testbench for lfm_phase_gen. Expected ROM addresses are
//   hand-computed and queued in exp_q. Each sample is then compared with the
//   head of that queue.
// -----------------------------------------------------------------------------
module tb_lfm_phase_gen;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 12;
  localparam int DUR_W   = 16;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET;
  logic dbg_state;

  always #5 CLK = ~CLK;

  lfm_phase_gen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W)) bus ();

  lfm_phase_gen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DUR_W(DUR_W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];

  // Advance one rising edge, then move 1 ns past it so outputs have settled.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input logic [31:0] fs, input logic [31:0] st, input logic [15:0] d);
    bus.F_START  = fs;
    bus.F_STEP   = st;
    bus.DURATION = d;
  endtask

  // Pulse START for one edge (edge k) and check that the burst was accepted.
  task automatic accept_start(input string tag);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk({tag, "_start_pulse"}, bus.SIGN_LFM_START_CALC, 1);
    chk({tag, "_busy_k"},      bus.BUSY, 1);
    chk({tag, "_valid_k"},     bus.ADDR_VALID, 0);
  endtask

  // Check n samples against the queued addresses. STOP must be high on the last.
  task automatic check_samples(input string tag, input int n);
    logic [ADDR_W-1:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      chk($sformatf("%s_addr%0d", tag, i),  bus.ROM_ADDR, e);
      chk($sformatf("%s_valid%0d", tag, i), bus.ADDR_VALID, 1);
      chk($sformatf("%s_stop%0d", tag, i),  bus.SIGN_LFM_STOP_CALC, (i == n - 1) ? 1 : 0);
      chk($sformatf("%s_spulse%0d", tag, i), bus.SIGN_LFM_START_CALC, 0);
      chk($sformatf("%s_busy%0d", tag, i),  bus.BUSY, 1);
    end
  endtask

  // The first idle edge after the burst clears the bus.
  task automatic check_exit(input string tag);
    tick();
    chk({tag, "_exit_busy"},  bus.BUSY, 0);
    chk({tag, "_exit_valid"}, bus.ADDR_VALID, 0);
    chk({tag, "_exit_addr"},  bus.ROM_ADDR, 0);
    chk({tag, "_exit_stop"},  bus.SIGN_LFM_STOP_CALC, 0);
    chk({tag, "_exit_state"}, dbg_state, 0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_spulse"}, bus.SIGN_LFM_START_CALC, 0);
    chk({tag, "_stop"},   bus.SIGN_LFM_STOP_CALC, 0);
    chk({tag, "_busy"},   bus.BUSY, 0);
    chk({tag, "_valid"},  bus.ADDR_VALID, 0);
    chk({tag, "_state"},  dbg_state, 0);
  endtask

  initial begin
    RESET        = 1'b1;
    bus.START    = 1'b0;
    bus.DS_READY = 1'b1;
    set_req(32'h0, 32'h0, 16'd0);
    tick();
    tick();
    check_quiet("reset");
    chk("reset_addr", bus.ROM_ADDR, 0);
    RESET = 1'b0;
    tick();

    // 1: constant tone, addresses 0..3
    set_req(32'h0010_0000, 32'h0, 16'd4);
    exp_q = '{12'h000, 12'h001, 12'h002, 12'h003};
    accept_start("t1");
    check_samples("t1", 4);
    check_exit("t1");

    // 2: up-chirp from zero. freq 0,1,2,3,4 (x2^20) gives phases 0,0,1,3,6.
    set_req(32'h0, 32'h0010_0000, 16'd5);
    exp_q = '{12'h000, 12'h000, 12'h001, 12'h003, 12'h006};
    accept_start("t2");
    check_samples("t2", 5);
    check_exit("t2");

    // 3a: half-turn tuning word, the phase wraps back to 0
    set_req(32'h8000_0000, 32'h0, 16'd3);
    exp_q = '{12'h000, 12'h800, 12'h000};
    accept_start("t3a");
    check_samples("t3a", 3);
    check_exit("t3a");

    // 3b: down-chirp. freq 2,1,0 gives phases 0,2,3.
    set_req(32'h0020_0000, 32'hFFF0_0000, 16'd3);
    exp_q = '{12'h000, 12'h002, 12'h003};
    accept_start("t3b");
    check_samples("t3b", 3);
    check_exit("t3b");

    // 4: phases land exactly on half a ROM step (0, 0.5, 1.0)
    set_req(32'h0008_0000, 32'h0, 16'd3);
`ifdef LFM_ADDR_ROUND_EN
    exp_q = '{12'h000, 12'h001, 12'h001};
`else
    exp_q = '{12'h000, 12'h000, 12'h001};
`endif
    accept_start("t4");
    check_samples("t4", 3);
    check_exit("t4");

    // 5a: DURATION = 0 is rejected
    set_req(32'h0010_0000, 32'h0, 16'd0);
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_quiet("t5a_k");
    tick();
    check_quiet("t5a_k1");

    // 5b: DS_READY low is rejected
    set_req(32'h0010_0000, 32'h0, 16'd3);
    bus.DS_READY = 1'b0;
    bus.START    = 1'b1;
    tick();
    bus.START    = 1'b0;
    check_quiet("t5b_k");
    tick();
    check_quiet("t5b_k1");
    bus.DS_READY = 1'b1;

    // 5c: START held through a burst with different fields is ignored. A START
    //     on the first idle edge (k+D+1) is accepted.
    set_req(32'h0010_0000, 32'h0, 16'd4);
    exp_q = '{12'h000, 12'h001, 12'h002, 12'h003};
    accept_start("t5c");
    set_req(32'h0040_0000, 32'h0010_0000, 16'd9);
    bus.START = 1'b1;
    check_samples("t5c", 4);
    set_req(32'h0030_0000, 32'h0, 16'd2);
    tick();                               // edge k+D+1: new burst accepted
    bus.START = 1'b0;
    chk("t5c_restart_pulse", bus.SIGN_LFM_START_CALC, 1);
    chk("t5c_restart_busy",  bus.BUSY, 1);
    chk("t5c_restart_valid", bus.ADDR_VALID, 0);
    chk("t5c_restart_stop",  bus.SIGN_LFM_STOP_CALC, 0);
    exp_q = '{12'h000, 12'h003};
    check_samples("t5d", 2);
    check_exit("t5d");

    // 6: reset on the third sample aborts the burst. RESET also overrides a START.
    set_req(32'h0010_0000, 32'h0, 16'd10);
    exp_q = '{12'h000, 12'h001, 12'h002};
    accept_start("t6");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_addr%0d", i), bus.ROM_ADDR, exp_q.pop_front());
      chk($sformatf("t6_stop%0d", i), bus.SIGN_LFM_STOP_CALC, 0);
    end
    RESET     = 1'b1;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    check_quiet("t6_rst");
    chk("t6_rst_addr", bus.ROM_ADDR, 0);
    RESET = 1'b0;
    tick();
    check_quiet("t6_rel");
    set_req(32'h0020_0000, 32'h0, 16'd3);
    exp_q = '{12'h000, 12'h002, 12'h004};
    accept_start("t6n");
    check_samples("t6n", 3);
    check_exit("t6n");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lfm_phase_gen.md
# lfm_phase_gen

Upstream LFM phase generator for the digital synthesizer. On a start request it runs a 32-bit phase accumulator whose tuning word ramps linearly (chirp) for a programmed number of samples. Each cycle it drives the sine-ROM address and brackets the burst with one-cycle `SIGN_LFM_START_CALC` / `SIGN_LFM_STOP_CALC` pulses. Those pulses go to the output register, which gates ROM data to the DAC bus.

## Interface
- `PHASE_W`, 32, phase accumulator and tuning-word width
- `ADDR_W`, 12, ROM address width (top `ADDR_W` bits of phase)
- `DUR_W`, 16, sample-count width
- `CLK`  in  1  clock, rising edge
- `RESET`  in  1  synchronous, active-high reset
- `START`  in  1  request pulse; sampled only in IDLE
- `DS_READY`  in  1  downstream output register idle; `START` ignored while low
- `F_START`  in  `PHASE_W`  initial tuning word, latched on accepted `START`
- `F_STEP`  in  `PHASE_W`  per-sample tuning-word increment, two's complement (down-chirp allowed), latched
- `DURATION`  in  `DUR_W`  samples per burst, latched; 0 = request rejected
- `BUSY`  out  1  burst in progress
- `ROM_ADDR`  out  `ADDR_W`  sine-ROM address
- `ADDR_VALID`  out  1  `ROM_ADDR` carries a burst sample
- `SIGN_LFM_START_CALC`  out  1  one-cycle burst-start pulse
- `SIGN_LFM_STOP_CALC`  out  1  one-cycle pulse coincident with last valid address

## Operation
- States: IDLE, RUN.
- **IDLE:** accept when `START && DS_READY && DURATION != 0`. On accept:
  - latch `F_STEP` and `DURATION`
  - phase <= 0, freq <= `F_START`, cnt <= 0
  - `SIGN_LFM_START_CALC` <= 1, `BUSY` <= 1
  - -> RUN
- **RUN**, each edge:
  - `ROM_ADDR` <= addr(phase), `ADDR_VALID` <= 1
  - phase <= phase + freq, freq <= freq + `F_STEP`, cnt <= cnt + 1
  - when cnt == `DURATION`-1: also `SIGN_LFM_STOP_CALC` <= 1 and -> IDLE
- **Exit:** on the first IDLE edge after RUN, `ADDR_VALID`, `BUSY` and `ROM_ADDR` are cleared to 0.
- addr(phase) = phase[`PHASE_W`-1 -: `ADDR_W`] (truncation; see Configuration).
- Arithmetic: phase and freq are modulo 2^`PHASE_W`, silent wrap, no saturation. The cnt compare is unsigned.
- **Rejected starts (no pulses, no state change):**
  - `START` while `BUSY`
  - `START` with `DURATION` == 0
  - `START` with `DS_READY` low
- Input changes after acceptance have no effect on the running burst.
- **Reset:** all outputs 0, state IDLE, phase/freq/cnt 0. Reset mid-burst aborts immediately with no STOP pulse, and overrides a simultaneous `START`.

## Timing
- Accepted `START` at edge k:
  - `SIGN_LFM_START_CALC` high for cycle k..k+1 only.
  - `ADDR_VALID` high after edges k+1 … k+`DURATION`; sample i (0-based) is presented after edge k+1+i.
  - `SIGN_LFM_STOP_CALC` high only after edge k+`DURATION`, together with the last address.
  - `BUSY` high after edges k … k+`DURATION`, low after k+`DURATION`+1.
- Earliest next accepted `START`: edge k+`DURATION`+1, one idle cycle between bursts minimum.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- **`LFM_ADDR_ROUND_EN` defined:** addr = top `ADDR_W` bits of (phase + 2^(`PHASE_W`-`ADDR_W`-1)), modulo 2^`PHASE_W`. This rounds to the nearest ROM entry and wraps 0xFFF+half to 0.
- **Not defined:** plain truncation of the phase.
- Timing and pulses are identical either way.

## Test plan
1. `F_START`=0x0010_0000, `F_STEP`=0, `DURATION`=4 -> `ROM_ADDR` 0,1,2,3 with `ADDR_VALID`; START pulse at k+0, STOP with address 3; `BUSY` low at k+5.
2. `F_START`=0, `F_STEP`=0x0010_0000, `DURATION`=5 -> addresses 0,0,1,3,6.
3. `F_START`=0x8000_0000, `F_STEP`=0, `DURATION`=3 -> addresses 0,0x800,0 (phase wrap). With `F_STEP`=0xFFF0_0000 and `F_START`=0x0020_0000 -> freq decreases 2,1,0 (×2^20), giving addresses 0,2,3.
4. `F_START`=0x0008_0000, `DURATION`=3 -> addresses 0,0,1 without `LFM_ADDR_ROUND_EN`; 0,1,1 with it.
5. Rejected starts:
   - `START` with `DURATION`=0 -> no pulses.
   - `START` with `DS_READY`=0 -> no pulses.
   - `START` mid-burst -> ignored; the burst completes unchanged.
6. `RESET` asserted at the 3rd sample of a `DURATION`=10 burst -> next cycle all outputs 0, no STOP pulse. A new `START` one cycle after reset release is accepted normally.
